addsub_arbiter: RTL and testbench



---
 rtl/addsub_arbiter_if.sv | 46 ++++
 rtl/addsub_arbiter.sv | 140 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Request, shared-datapath and response signals of addsub_arbiter.
// slave is the arbiter side; master is the requester/datapath/consumer side.
interface addsub_arbiter_if #(
  parameter int WIDTH = 7
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  add_sum, rsp_ready,
    output req0_ready, req1_ready,
    output add_a, add_b, add_sub,
    output rsp_valid, rsp_id, rsp_sum, rsp_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output add_sum, rsp_ready,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_sub,
    input  rsp_valid, rsp_id, rsp_sum, rsp_ovf
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one external add/sub datapath between two requesters.
// Optional: define ADDSUB_OVF_DETECT_EN to register two's-complement overflow in rsp_ovf.
module addsub_arbiter #(
  parameter int WIDTH = 7
) (
  input  logic              clk,
  input  logic              reset,
  addsub_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             last_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             id_q;

  logic [WIDTH-1:0] sum_q;
  logic             rid_q;

  logic             grant_v;
  logic             grant_id;

  // Pick a winner in IDLE; on contention the requester not served last wins.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = 1'b0;
    if (state_q == IDLE) begin
      unique case ({bus.req1_valid, bus.req0_valid})
        2'b01: begin
          grant_v  = 1'b1;
          grant_id = 1'b0;
        end
        2'b10: begin
          grant_v  = 1'b1;
          grant_id = 1'b1;
        end
        2'b11: begin
          grant_v  = 1'b1;
          grant_id = ~last_q;
        end
        default: begin
          grant_v  = 1'b0;
          grant_id = 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = grant_v & ~grant_id;
  assign bus.req1_ready = grant_v & grant_id;

  // Next-state: accept -> one execute cycle -> hold result until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_v) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the winning request; these registers feed the datapath in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else if (grant_v) begin
      a_q    <= grant_id ? bus.req1_a   : bus.req0_a;
      b_q    <= grant_id ? bus.req1_b   : bus.req0_b;
      sub_q  <= grant_id ? bus.req1_sub : bus.req0_sub;
      id_q   <= grant_id;
      last_q <= grant_id;
    end
  end

  assign bus.add_a   = a_q;
  assign bus.add_b   = b_q;
  assign bus.add_sub = sub_q;

  // Register the datapath result at the end of the execute cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
      rid_q <= 1'b0;
    end else if (state_q == EXEC) begin
      sum_q <= bus.add_sum;
      rid_q <= id_q;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_id    = rid_q;

`ifdef ADDSUB_OVF_DETECT_EN
  logic ovf_d;
  logic ovf_q;

  // Overflow: operand signs that can overflow, and a result sign differing from a.
  always_comb begin
    ovf_d = 1'b0;
    if (sub_q)
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
              (bus.add_sum[WIDTH-1] != a_q[WIDTH-1]);
    else
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
              (bus.add_sum[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Overflow flag is registered alongside the sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ovf_q <= 1'b0;
    else if (state_q == EXEC)  ovf_q <= ovf_d;
  end

  assign bus.rsp_ovf = ovf_q;
`else
  assign bus.rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed plus randomized bench for addsub_arbiter.
// Expected results come from signed/unsigned integer arithmetic and a round-robin model.
module tb_addsub_arbiter;
  localparam int W    = 7;
  localparam int MASK = (1 << W) - 1;
`ifdef ADDSUB_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  addsub_arbiter_if #(.WIDTH(W)) bus ();

  assign bus.add_sum = bus.add_sub ? bus.add_a - bus.add_b
                                   : bus.add_a + bus.add_b;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit last_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_s(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic int m_sum(input int a, input int b, input bit s);
    return (s ? a - b : a + b) & MASK;
  endfunction

  function automatic bit m_ovf(input int a, input int b, input bit s);
    int r;
    r = s ? to_s(a) - to_s(b) : to_s(a) + to_s(b);
    return OVF_EN && (r > (1 << (W - 1)) - 1 || r < -(1 << (W - 1)));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit v0, input bit v1,
                    input int a0, input int b0, input bit s0,
                    input int a1, input int b1, input bit s1,
                    input bit keep, input int stall);
    bit win;
    int wa;
    int wb;
    bit ws;
    int es;
    bit eo;
    bus.req0_valid = v0;
    bus.req0_a     = a0[W-1:0];
    bus.req0_b     = b0[W-1:0];
    bus.req0_sub   = s0;
    bus.req1_valid = v1;
    bus.req1_a     = a1[W-1:0];
    bus.req1_b     = b1[W-1:0];
    bus.req1_sub   = s1;
    bus.rsp_ready  = (stall == 0);
    win = (v0 && v1) ? ~last_m : v1;
    wa  = win ? a1 : a0;
    wb  = win ? b1 : b0;
    ws  = win ? s1 : s0;
    es  = m_sum(wa, wb, ws);
    eo  = m_ovf(wa, wb, ws);
    #1;
    chk("idle_ready0", bus.req0_ready, !win);
    chk("idle_ready1", bus.req1_ready, win);
    tick();
    last_m = win;
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    #1;
    chk("exec_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    chk("exec_add_a", bus.add_a, wa & MASK);
    chk("exec_add_b", bus.add_b, wb & MASK);
    chk("exec_add_sub", bus.add_sub, ws);
    tick();
    for (int i = 0; i <= stall; i++) begin
      chk("resp_valid", bus.rsp_valid, 1);
      chk("resp_sum", bus.rsp_sum, es);
      chk("resp_id", bus.rsp_id, win);
      chk("resp_ovf", bus.rsp_ovf, eo);
      chk("resp_ready", {bus.req1_ready, bus.req0_ready}, 0);
      chk("resp_add_a", bus.add_a, wa & MASK);
      chk("resp_add_sub", bus.add_sub, ws);
      if (i == stall) bus.rsp_ready = 1'b1;
      tick();
    end
    chk("post_rsp_valid", bus.rsp_valid, 0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_sub   = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_sub   = 1'b0;
    bus.rsp_ready  = 1'b0;
    #22;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_sum", bus.rsp_sum, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_ovf", bus.rsp_ovf, 0);
    chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("rst_add", {bus.add_sub, bus.add_a, bus.add_b}, 0);
    @(negedge clk);
    reset  = 1'b0;
    last_m = 1'b1;
    tick();
    chk("idle_no_valid", bus.rsp_valid, 0);
    chk("idle_no_ready", {bus.req1_ready, bus.req0_ready}, 0);

    op(1, 0, 5, 3, 0, 0, 0, 0, 0, 0);
    op(0, 1, 0, 0, 0, 10, 12, 1, 0, 0);

    for (int k = 0; k < 4; k++)
      op(1, 1, 20, 7, 0, 33, 50, 1, 1, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    op(1, 1, 100, 27, 1, 90, 45, 0, 1, 5);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    op(1, 0, 63, 1, 0, 0, 0, 0, 0, 0);
    op(0, 1, 0, 0, 0, 64, 1, 1, 0, 0);

    for (int k = 0; k < 30; k++) begin
      int v;
      v = $urandom_range(1, 3);
      op(v[0], v[1],
         $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 1) != 0,
         $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 1) != 0,
         $urandom_range(0, 1) != 0, $urandom_range(0, 3));
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("rand_idle_valid", bus.rsp_valid, 0);
      end
    end

    bus.req0_valid = 1'b1;
    bus.req0_a     = 7'd9;
    bus.req0_b     = 7'd4;
    bus.req0_sub   = 1'b1;
    bus.rsp_ready  = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_sum", bus.rsp_sum, 0);
    chk("arst_rsp_id", bus.rsp_id, 0);
    chk("arst_rsp_ovf", bus.rsp_ovf, 0);
    chk("arst_add", {bus.add_sub, bus.add_a, bus.add_b}, 0);
    chk("arst_ready", {bus.req1_ready, bus.req0_ready}, 0);
    @(negedge clk);
    reset  = 1'b0;
    last_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_no_rsp", bus.rsp_valid, 0);
    end
    op(1, 1, 11, 22, 0, 44, 3, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
